// File: rtl/aurora_pkg.sv
// Shared types and parameter defaults for the Aurora link monitor.
package aurora_pkg;

  typedef enum logic [2:0] {
    ST_PB_ON,
    ST_PMA_ON,
    ST_PMA_OFF,
    ST_WAIT_UP,
    ST_UP
  } state_e;

  localparam int DEF_LANES      = 4;
  localparam int DEF_PB_LEAD    = 128;
  localparam int DEF_PMA_HOLD   = 1024;
  localparam int DEF_UP_STABLE  = 16;
  localparam int DEF_UP_TIMEOUT = 2**24;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/aurora_timer.sv
// Loadable down-counter; done_o flags the last cycle of a loaded interval,
// idle_o means nothing has been loaded (or the interval has fully drained).
module aurora_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o,
  output logic         idle_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign done_o = (count_q == W'(1));
  assign idle_o = (count_q == '0);

endmodule

// File: rtl/aurora_link_monitor.sv
// Aurora bring-up sequencer: reset_pb / pma_init power-up ordering, channel
// stability qualification, retry on loss or timeout, and error counting.
module aurora_link_monitor
  import aurora_pkg::*;
#(
  parameter int LANES      = DEF_LANES,
  parameter int PB_LEAD    = DEF_PB_LEAD,
  parameter int PMA_HOLD   = DEF_PMA_HOLD,
  parameter int UP_STABLE  = DEF_UP_STABLE,
  parameter int UP_TIMEOUT = DEF_UP_TIMEOUT
) (
  input  logic             clk156,
  input  logic             reset,
  input  logic             channel_up,
  input  logic [LANES-1:0] lane_up,
  input  logic             hard_err,
  input  logic             soft_err,
  output logic             reset_pb,
  output logic             pma_init,
  output logic             link_ok,
  output logic [7:0]       retry_count,
  output logic [15:0]      soft_err_count
);

  localparam int TW = $clog2(max3(PB_LEAD, PMA_HOLD, UP_TIMEOUT) + 1);
  localparam int SW = $clog2(UP_STABLE + 1);

  state_e          state_q, state_d;
  logic [SW-1:0]   stable_q, stable_d;
  logic [7:0]      retry_q, retry_d;
  logic [15:0]     soft_q, soft_d;
  logic            reset_pb_q, reset_pb_d;
  logic            pma_init_q, pma_init_d;
  logic            link_ok_q, link_ok_d;
  logic            retry_inc;
  logic            lanes_good;
  logic            timer_load, timer_done, timer_idle;
  logic [TW-1:0]   timer_val;

  assign lanes_good = channel_up & (&lane_up);

  always_ff @(posedge clk156 or posedge reset) begin
    if (reset) begin
      state_q <= ST_PB_ON;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    retry_inc = 1'b0;
    case (state_q)
      ST_PB_ON:   if (timer_done) state_d = ST_PMA_ON;
      ST_PMA_ON:  if (timer_done) state_d = ST_PMA_OFF;
      ST_PMA_OFF: if (timer_done) state_d = ST_WAIT_UP;
      ST_WAIT_UP: begin
        // A hard error beats qualification; reaching UP beats a same-cycle timeout.
        if (hard_err) begin
          state_d   = ST_PB_ON;
          retry_inc = 1'b1;
        end else if (lanes_good && (stable_q == SW'(UP_STABLE - 1))) begin
          state_d = ST_UP;
        end else if (timer_done) begin
          state_d   = ST_PB_ON;
          retry_inc = 1'b1;
        end
      end
      ST_UP: begin
        if (!lanes_good || hard_err) begin
          state_d   = ST_PB_ON;
          retry_inc = 1'b1;
        end
      end
      default: state_d = ST_PB_ON;
    endcase
  end

  always_comb begin
    reset_pb_d = (state_d == ST_PB_ON) || (state_d == ST_PMA_ON) || (state_d == ST_PMA_OFF);
    pma_init_d = (state_d == ST_PMA_ON);
    link_ok_d  = (state_d == ST_UP);
  end

  // An idle timer in a timed state only happens straight after reset, so the
  // first edge loads the full interval just like a normal state entry.
  assign timer_load = (state_d != state_q) || timer_idle;

  always_comb begin
    timer_val = '0;
    case (state_d)
      ST_PB_ON:   timer_val = TW'(PB_LEAD);
      ST_PMA_ON:  timer_val = TW'(PMA_HOLD);
      ST_PMA_OFF: timer_val = TW'(PB_LEAD);
      ST_WAIT_UP: timer_val = TW'(UP_TIMEOUT);
      default:    timer_val = '0;
    endcase
  end

  aurora_timer #(.W(TW)) u_timer (
    .clk        (clk156),
    .rst        (reset),
    .load_i     (timer_load),
    .load_val_i (timer_val),
    .done_o     (timer_done),
    .idle_o     (timer_idle)
  );

  always_comb begin
    stable_d = '0;
    if ((state_q == ST_WAIT_UP) && (state_d == ST_WAIT_UP) && lanes_good) begin
      stable_d = stable_q + 1'b1;
    end
    retry_d = retry_q;
    if (retry_inc && (retry_q != 8'hFF)) begin
      retry_d = retry_q + 1'b1;
    end
    soft_d = soft_q;
    if ((state_q == ST_UP) && soft_err && (soft_q != 16'hFFFF)) begin
      soft_d = soft_q + 1'b1;
    end
  end

  always_ff @(posedge clk156 or posedge reset) begin
    if (reset) begin
      stable_q   <= '0;
      retry_q    <= '0;
      soft_q     <= '0;
      reset_pb_q <= 1'b1;
      pma_init_q <= 1'b0;
      link_ok_q  <= 1'b0;
    end else begin
      stable_q   <= stable_d;
      retry_q    <= retry_d;
      soft_q     <= soft_d;
      reset_pb_q <= reset_pb_d;
      pma_init_q <= pma_init_d;
      link_ok_q  <= link_ok_d;
    end
  end

  assign reset_pb       = reset_pb_q;
  assign pma_init       = pma_init_q;
  assign link_ok        = link_ok_q;
  assign retry_count    = retry_q;
  assign soft_err_count = soft_q;

endmodule

// File: tb/tb_aurora_link_monitor.sv
// Directed bench for aurora_link_monitor with a phase/elapsed-time reference
// model checked every cycle plus hand-computed milestone checks.
module tb_aurora_link_monitor;

  localparam int LANES      = 4;
  localparam int PB_LEAD    = 4;
  localparam int PMA_HOLD   = 8;
  localparam int UP_STABLE  = 3;
  localparam int UP_TIMEOUT = 20;

  logic             clk156 = 1'b0;
  logic             reset = 1'b1;
  logic             channel_up = 1'b0;
  logic [LANES-1:0] lane_up = '0;
  logic             hard_err = 1'b0;
  logic             soft_err = 1'b0;
  logic             reset_pb, pma_init, link_ok;
  logic [7:0]       retry_count;
  logic [15:0]      soft_err_count;

  int vectors = 0;
  int miscompares = 0;

  aurora_link_monitor #(
    .LANES(LANES), .PB_LEAD(PB_LEAD), .PMA_HOLD(PMA_HOLD),
    .UP_STABLE(UP_STABLE), .UP_TIMEOUT(UP_TIMEOUT)
  ) dut (
    .clk156         (clk156),
    .reset          (reset),
    .channel_up     (channel_up),
    .lane_up        (lane_up),
    .hard_err       (hard_err),
    .soft_err       (soft_err),
    .reset_pb       (reset_pb),
    .pma_init       (pma_init),
    .link_ok        (link_ok),
    .retry_count    (retry_count),
    .soft_err_count (soft_err_count)
  );

  always #5 clk156 = ~clk156;

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0..4 = PB_ON, PMA_ON, PMA_OFF, WAIT_UP, UP.
  // m_smp counts post-edge cycles already spent in the phase.
  int m_ph, m_smp, m_run, m_retry, m_soft;

  function automatic int dur(input int ph);
    return (ph == 1) ? PMA_HOLD : PB_LEAD;
  endfunction

  always @(posedge clk156 or posedge reset) begin : model
    int ph, smp, run, rty, sft;
    bit good, retry;
    if (reset) begin
      m_ph <= 0; m_smp <= 0; m_run <= 0; m_retry <= 0; m_soft <= 0;
    end else begin
      ph = m_ph; smp = m_smp; run = m_run; rty = m_retry; sft = m_soft;
      retry = 1'b0;
      good = channel_up && (lane_up == 4'hF);
      if (ph == 4 && soft_err && sft < 65535) sft = sft + 1;
      case (ph)
        0, 1, 2: begin
          if (smp == dur(ph)) begin ph = ph + 1; smp = 1; run = 0; end
          else smp = smp + 1;
        end
        3: begin
          if (hard_err) retry = 1'b1;
          else if (good && run + 1 == UP_STABLE) begin ph = 4; smp = 1; end
          else if (smp == UP_TIMEOUT) retry = 1'b1;
          else begin smp = smp + 1; run = good ? run + 1 : 0; end
        end
        default: if (!good || hard_err) retry = 1'b1;
      endcase
      if (retry) begin
        ph = 0; smp = 1; run = 0;
        rty = (rty < 255) ? rty + 1 : 255;
      end
      m_ph <= ph; m_smp <= smp; m_run <= run; m_retry <= rty; m_soft <= sft;
    end
  end

  always @(negedge clk156) begin
    if (!reset) begin
      chk("cyc_reset_pb", reset_pb, (m_ph < 3) ? 1 : 0);
      chk("cyc_pma_init", pma_init, (m_ph == 1) ? 1 : 0);
      chk("cyc_link_ok", link_ok, (m_ph == 4) ? 1 : 0);
      chk("cyc_retry_count", retry_count, m_retry);
      chk("cyc_soft_err_count", soft_err_count, m_soft);
    end
  end

  // which: 0 reset_pb, 1 pma_init, 2 link_ok. Returns at the first negedge where it matches.
  task automatic wait_for(input string name, input int which, input logic val, input int bound);
    logic s;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk156);
      s = (which == 0) ? reset_pb : (which == 1) ? pma_init : link_ok;
      if (s == val) return;
    end
    chk(name, 0, 1);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int rpb_cnt, pma_cnt, pma_first, rise;
    repeat (3) @(negedge clk156);
    chk("reset_state_reset_pb", reset_pb, 1);
    chk("reset_state_pma_init", pma_init, 0);
    chk("reset_state_link_ok", link_ok, 0);
    chk("reset_state_retry", retry_count, 0);
    reset = 1'b0;

    // Power-up sequence.
    rpb_cnt = 0; pma_cnt = 0; pma_first = -1;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk156);
      if (reset_pb) rpb_cnt++;
      if (pma_init) begin
        pma_cnt++;
        if (pma_first < 0) pma_first = k;
      end
    end
    chk("powerup_reset_pb_cycles", rpb_cnt, 16);
    chk("powerup_pma_init_cycles", pma_cnt, 8);
    chk("powerup_pma_first_cycle", pma_first, 5);
    $display("[powerup] reset_pb=%0d cycles pma_init=%0d cycles from cycle %0d", rpb_cnt, pma_cnt, pma_first);

    // Clean channel-up qualification.
    channel_up = 1'b1; lane_up = 4'hF;
    rise = -1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk156);
      if (link_ok && rise < 0) rise = k;
    end
    chk("up_clean_latency", rise, 3);
    $display("[link_up] link_ok rose %0d cycles after channel/lanes up", rise);

    // Soft errors in UP, then channel loss.
    for (int k = 0; k < 10; k++) begin
      soft_err = (k % 2 == 0);
      @(negedge clk156);
    end
    soft_err = 1'b0;
    @(negedge clk156);
    chk("soft_in_up", soft_err_count, 5);
    channel_up = 1'b0;
    @(negedge clk156);
    chk("chan_drop_link_ok", link_ok, 0);
    chk("chan_drop_reset_pb", reset_pb, 1);
    chk("chan_drop_retry", retry_count, 1);
    $display("[chan_drop] retry_count=%0d soft_err_count=%0d", retry_count, soft_err_count);

    // Hard error during PMA_ON is ignored.
    wait_for("wait_pma_on", 1, 1'b1, 40);
    hard_err = 1'b1;
    @(negedge clk156);
    hard_err = 1'b0;
    wait_for("wait_wait_up_1", 0, 1'b0, 40);
    chk("hard_in_pma_retry", retry_count, 1);
    $display("[hard_pma] retry_count=%0d after hard_err in PMA_ON", retry_count);

    // Dropout on the third good sample plus soft errors while still in WAIT_UP.
    rise = -1;
    for (int k = 0; k < 9; k++) begin
      channel_up = (k != 2);
      lane_up    = 4'hF;
      soft_err   = (k < 3);
      @(negedge clk156);
      if (link_ok && rise < 0) rise = k + 1;
    end
    soft_err = 1'b0;
    chk("up_dropout_latency", rise, 6);
    chk("soft_in_wait_ignored", soft_err_count, 5);
    $display("[dropout] link_ok rose after %0d cycles, soft_err_count=%0d", rise, soft_err_count);

    // Hard error in UP.
    hard_err = 1'b1;
    @(negedge clk156);
    hard_err = 1'b0;
    channel_up = 1'b0;
    chk("hard_up_link_ok", link_ok, 0);
    chk("hard_up_retry", retry_count, 2);
    $display("[hard_up] retry_count=%0d", retry_count);

    // Hard error coinciding with the WAIT_UP timeout edge.
    wait_for("wait_wait_up_2", 0, 1'b0, 40);
    repeat (UP_TIMEOUT - 1) @(negedge clk156);
    chk("pre_timeout_in_wait", reset_pb, 0);
    hard_err = 1'b1;
    @(negedge clk156);
    hard_err = 1'b0;
    chk("hard_timeout_retry", retry_count, 3);
    chk("hard_timeout_reset_pb", reset_pb, 1);
    $display("[hard_timeout] retry_count=%0d", retry_count);

    // Repeated timeouts until saturation.
    repeat (255 * 36) @(negedge clk156);
    chk("retry_saturated", retry_count, 255);
    repeat (40) @(negedge clk156);
    chk("retry_stays_saturated", retry_count, 255);
    $display("[saturate] retry_count=%0d", retry_count);

    // Asynchronous reset in the middle of PMA_ON.
    wait_for("wait_pma_on_2", 1, 1'b1, 40);
    @(negedge clk156);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_pma_init", pma_init, 0);
    chk("async_rst_reset_pb", reset_pb, 1);
    chk("async_rst_retry", retry_count, 0);
    chk("async_rst_soft", soft_err_count, 0);
    repeat (2) @(negedge clk156);
    reset = 1'b0;
    pma_first = -1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk156);
      if (pma_init && pma_first < 0) pma_first = k;
    end
    chk("restart_pma_first_cycle", pma_first, 5);
    $display("[async_reset] pma_init cleared before edge, restart pma_init at cycle %0d", pma_first);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/aurora_link_monitor.md
AURORA_LINK_MONITOR -- requirements
Module: aurora_link_monitor

Interface
REQ-001 SHALL have parameter LANES, default 4, the number of Aurora lanes observed.
REQ-002 SHALL have parameter PB_LEAD, default 128, the number of cycles reset_pb leads pma_init assertion and trails its release.
REQ-003 SHALL have parameter PMA_HOLD, default 1024, the number of cycles pma_init is held high.
REQ-004 SHALL have parameter UP_STABLE, default 16, the number of consecutive cycles with channel_up high required before the link is declared up.
REQ-005 SHALL have parameter UP_TIMEOUT, default 2**24, the cycles allowed in WAIT_UP before a retry (about 107 ms at 156.25 MHz).
REQ-006 SHALL have port clk156, input, 1 bit: the single clock.
REQ-007 SHALL have port reset, input, 1 bit: reset, asynchronous and active-high.
REQ-008 SHALL have port channel_up, input, 1 bit: Aurora channel status.
REQ-009 SHALL have port lane_up, input, LANES bits: per-lane status.
REQ-010 SHALL have port hard_err, input, 1 bit: Aurora hard error pulse.
REQ-011 SHALL have port soft_err, input, 1 bit: Aurora soft error pulse.
REQ-012 SHALL have port reset_pb, output, 1 bit: Aurora reset_pb request.
REQ-013 SHALL have port pma_init, output, 1 bit: Aurora pma_init request.
REQ-014 SHALL have port link_ok, output, 1 bit: high only in state UP.
REQ-015 SHALL have port retry_count, output, 8 bits: saturating count of reset retries.
REQ-016 SHALL have port soft_err_count, output, 16 bits: saturating count of soft errors while UP.

Function
REQ-017 SHALL implement the states PB_ON, PMA_ON, PMA_OFF, WAIT_UP and UP, with all outputs registered.
REQ-018 SHALL, in PB_ON, drive reset_pb=1 and pma_init=0, and go to PMA_ON after exactly PB_LEAD cycles.
REQ-019 SHALL, in PMA_ON, drive reset_pb=1 and pma_init=1, and go to PMA_OFF after exactly PMA_HOLD cycles.
REQ-020 SHALL, in PMA_OFF, drive reset_pb=1 and pma_init=0, and go to WAIT_UP after exactly PB_LEAD cycles.
REQ-021 SHALL, in WAIT_UP, drive reset_pb=0 and pma_init=0, and count consecutive cycles with channel_up=1 and lane_up all ones; any low sample restarts that count.
REQ-022 SHALL enter UP when the stable count reaches UP_STABLE; link_ok rises in the same cycle the state becomes UP.
REQ-023 SHALL, when UP_TIMEOUT cycles elapse in WAIT_UP without reaching UP, go to PB_ON and increment retry_count.
REQ-024 SHALL, in UP, go to PB_ON and increment retry_count when channel_up=0, or any lane_up bit is 0, or hard_err=1.
REQ-025 SHALL increment soft_err_count in UP on each cycle soft_err=1, and SHALL ignore soft_err in every other state.
REQ-026 SHALL make retry_count and soft_err_count saturate at all ones, never wrap, and be cleared only by reset.
REQ-027 SHALL, when hard_err and a timeout occur in the same cycle, perform a single retry increment.
REQ-028 SHALL size every internal counter to the largest of its parameters, and SHALL reload each counter on state entry.
REQ-029 SHALL, on hard_err during PB_ON, PMA_ON or PMA_OFF, neither restart the sequence nor count a retry.

Reset
REQ-030 SHALL, on reset assertion, immediately set the state to PB_ON, reset_pb=1, pma_init=0, link_ok=0, both counts 0 and all timers 0.
REQ-031 SHALL, after reset release, begin counting PB_LEAD on the first clk156 edge.
REQ-032 SHALL, on reset asserted mid-sequence (for example in PMA_ON), drop pma_init to 0 asynchronously.

Structure
REQ-033 SHALL place the state enum and the parameter default constants in the shared package aurora_pkg.
REQ-034 SHALL use one sub-module, aurora_timer: a loadable down-counter with a done flag, instantiated once and shared across states.

Verification
REQ-035 SHALL cover power-up with PB_LEAD=4, PMA_HOLD=8, UP_STABLE=3: reset_pb high for 4+8+4 cycles, pma_init high for exactly 8 of them, centred.
REQ-036 SHALL cover channel_up and lane_up=4'hF held in WAIT_UP: link_ok=1 exactly 3 cycles after both go high; a 1-cycle dropout at cycle 2 delays it by 3.
REQ-037 SHALL cover channel_up falling while UP: link_ok=0 and reset_pb=1 the next cycle, and retry_count goes from 0 to 1.
REQ-038 SHALL cover UP_TIMEOUT=20 with no channel_up: retry every 20+16 cycles, retry_count saturating at 255 after 255 retries.
REQ-039 SHALL cover 5 soft_err pulses in UP and 3 in WAIT_UP: soft_err_count=5.
REQ-040 SHALL cover reset asserted mid-PMA_ON between clock edges: pma_init=0 before the next edge, and the sequence restarts from PB_ON.
